// File: rtl/bmem_arb_pkg.sv
// Shared types and default geometry for the bmem arbiter.
package bmem_arb_pkg;

    localparam int BURST_LEN_DEF = 4;
    localparam int BEAT_W_DEF    = 64;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ISSUE   = 3'd1,
        RD_COLLECT = 3'd2,
        WR_BURST   = 3'd3,
        RESP       = 3'd4
    } arb_state_t;

    typedef enum logic {
        SEL_I = 1'b0,
        SEL_D = 1'b1
    } arb_sel_t;

    // Cache lines are 32 bytes; bmem always sees the line base address.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~32'h0000_001F;
    endfunction

endpackage

// File: rtl/bmem_arbiter_arb_rr2.sv
// Two-way tie-break between instruction and data cache.
// BMEM_ARB_RR_EN defined: round-robin, last grantee loses a tie.
// BMEM_ARB_RR_EN undefined: data cache always wins a tie.
module arb_rr2
    import bmem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_req,
    input  logic     d_req,
    input  logic     take,
    output logic     gnt_valid,
    output arb_sel_t gnt
);

    arb_sel_t last_q;

    assign gnt_valid = i_req | d_req;

    // Remember the most recent grantee; reset value makes the data cache win the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= SEL_I;
        end else if (take) begin
            last_q <= gnt;
        end
    end

`ifdef BMEM_ARB_RR_EN
    // Tie goes to whichever requester was not served last
    always_comb begin
        gnt = SEL_I;
        if (i_req && d_req) begin
            gnt = (last_q == SEL_D) ? SEL_I : SEL_D;
        end else if (d_req) begin
            gnt = SEL_D;
        end
    end
`else
    logic unused_last;
    assign unused_last = (last_q == SEL_D);

    // Fixed priority: data cache first
    always_comb begin
        gnt = SEL_I;
        if (d_req) begin
            gnt = SEL_D;
        end
    end
`endif

endmodule

// File: rtl/bmem_arbiter.sv
// Shares one burst memory port between the instruction and data caches.
// One bmem transaction outstanding at a time; a full line is assembled or
// streamed out before the grantee is answered.
// Tie-break policy selected by BMEM_ARB_RR_EN (see arb_rr2).
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for a request, grant + latch addr/wdata
// RD_ISSUE   | bmem_read held until bmem_ready handshake
// RD_COLLECT | gathering BURST_LEN beats tagged with the latched address
// WR_BURST   | streaming write beats, advancing on bmem_ready
// RESP       | one-cycle response pulse to the grantee
module bmem_arbiter
    import bmem_arb_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int BEAT_W    = BEAT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_req,
    input  logic [31:0]                 i_addr,
    output logic                        i_resp,
    output logic [BURST_LEN*BEAT_W-1:0] i_rdata,
    input  logic                        d_req,
    input  logic                        d_we,
    input  logic [31:0]                 d_addr,
    input  logic [BURST_LEN*BEAT_W-1:0] d_wdata,
    output logic                        d_resp,
    output logic [BURST_LEN*BEAT_W-1:0] d_rdata,
    output logic [31:0]                 bmem_addr,
    output logic                        bmem_read,
    output logic                        bmem_write,
    output logic [BEAT_W-1:0]           bmem_wdata,
    input  logic                        bmem_ready,
    input  logic [31:0]                 bmem_raddr,
    input  logic [BEAT_W-1:0]           bmem_rdata,
    input  logic                        bmem_rvalid,
    output logic                        err
);

    localparam int               CNT_W     = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_t                  state;
    arb_sel_t                    sel_q;
    arb_sel_t                    gnt;
    logic                        gnt_valid;
    logic                        take;
    logic [31:0]                 addr_q;
    logic [CNT_W-1:0]            beat_cnt;
    logic [BEAT_W-1:0]           rbeats_q [BURST_LEN];
    logic [BEAT_W-1:0]           wbeats_q [BURST_LEN];
    logic [BURST_LEN*BEAT_W-1:0] line;
    logic                        raddr_match;

    assign take = (state == IDLE) && gnt_valid;

    arb_rr2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .d_req     (d_req),
        .take      (take),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    assign raddr_match = (bmem_raddr == addr_q);

    // Sequence one transaction: grant, bmem handshake, beat transfer, response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sel_q    <= SEL_D;
            addr_q   <= '0;
            beat_cnt <= '0;
            for (int k = 0; k < BURST_LEN; k++) begin
                rbeats_q[k] <= '0;
                wbeats_q[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        sel_q    <= gnt;
                        addr_q   <= line_align((gnt == SEL_D) ? d_addr : i_addr);
                        beat_cnt <= '0;
                        if ((gnt == SEL_D) && d_we) begin
                            for (int k = 0; k < BURST_LEN; k++) begin
                                wbeats_q[k] <= d_wdata[k*BEAT_W +: BEAT_W];
                            end
                            state <= WR_BURST;
                        end else begin
                            state <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (bmem_ready) begin
                        state <= RD_COLLECT;
                    end
                end
                RD_COLLECT: begin
                    if (bmem_rvalid && raddr_match) begin
                        rbeats_q[beat_cnt] <= bmem_rdata;
                        beat_cnt           <= beat_cnt + CNT_ONE;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= RESP;
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        beat_cnt <= beat_cnt + CNT_ONE;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error for beats that do not belong to the burst in flight; IDLE ignores leftovers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (bmem_rvalid && (state != IDLE) &&
                     !((state == RD_COLLECT) && raddr_match)) begin
            err <= 1'b1;
        end
    end

    // Assemble the read line, beat 0 in the least significant position
    always_comb begin
        line = '0;
        for (int k = 0; k < BURST_LEN; k++) begin
            line[k*BEAT_W +: BEAT_W] = rbeats_q[k];
        end
    end

    assign i_rdata    = line;
    assign d_rdata    = line;
    assign i_resp     = (state == RESP) && (sel_q == SEL_I);
    assign d_resp     = (state == RESP) && (sel_q == SEL_D);
    assign bmem_addr  = addr_q;
    assign bmem_read  = (state == RD_ISSUE);
    assign bmem_write = (state == WR_BURST);
    assign bmem_wdata = (state == WR_BURST) ? wbeats_q[beat_cnt] : '0;

endmodule

// File: doc/bmem_arbiter.md
BMEM_ARBITER -- requirements
Module: bmem_arbiter

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 4, meaning beats per cache line.
REQ-002 The block SHALL have parameter BEAT_W, default 64, meaning bits per bmem beat; line width LINE_W = BURST_LEN*BEAT_W (256).
REQ-003 The block SHALL have port clk  input  1  the single clock.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_req  input  1  instruction-cache line read request.
REQ-006 The block SHALL have port i_addr  input  32  instruction line address.
REQ-007 The block SHALL have ports i_resp (output, 1) and i_rdata (output, LINE_W) for the instruction-cache response.
REQ-008 The block SHALL have ports d_req (input, 1), d_we (input, 1), d_addr (input, 32) and d_wdata (input, LINE_W) for data-cache requests.
REQ-009 The block SHALL have ports d_resp (output, 1) and d_rdata (output, LINE_W) for the data-cache response.
REQ-010 The block SHALL have bmem ports bmem_addr (out, 32), bmem_read (out, 1), bmem_write (out, 1), bmem_wdata (out, BEAT_W), bmem_ready (in, 1), bmem_raddr (in, 32), bmem_rdata (in, BEAT_W) and bmem_rvalid (in, 1).
REQ-011 The block SHALL have port err  output  1  sticky flag for a stray or mismatched read beat.

Function
REQ-012 The block SHALL keep at most one bmem transaction outstanding.
REQ-013 The FSM SHALL have states IDLE, RD_ISSUE, RD_COLLECT, WR_BURST and RESP.
REQ-014 IDLE: on any asserted request, the FSM SHALL latch the grantee, its line-aligned address (addr[4:0]=0) and, for a write, its wdata, then go to RD_ISSUE if the request is a read or to WR_BURST if it is a write.
REQ-015 RD_ISSUE: the block SHALL drive bmem_read=1 and bmem_addr=latched address until it samples bmem_ready=1, then go to RD_COLLECT.
REQ-016 RD_COLLECT: on each bmem_rvalid with bmem_raddr equal to the latched address, the block SHALL store the beat at index beat_cnt and increment beat_cnt; the beat with beat_cnt=BURST_LEN-1 SHALL move the FSM to RESP.
REQ-017 On a bmem_rvalid with mismatched bmem_raddr, the beat SHALL be discarded and err set.
REQ-018 WR_BURST: the block SHALL drive bmem_write=1, bmem_addr=latched address and bmem_wdata=beat[beat_cnt]; beat_cnt SHALL advance only on cycles with bmem_ready=1; the last accepted beat SHALL move the FSM to RESP.
REQ-019 RESP: the block SHALL pulse exactly one cycle of i_resp or d_resp (grantee only) with the assembled line on the matching rdata, then return to IDLE. d_rdata is don't-care for writes.
REQ-020 Response latency: read = RD_ISSUE handshake + 4 beats + 1 cycle; write with bmem_ready held high = 4 + 1 cycles.
REQ-021 Requesters SHALL hold req/addr/wdata stable until their resp; the block SHALL NOT re-sample these inputs before returning to IDLE.
REQ-022 In IDLE, bmem_rvalid SHALL be ignored without setting err; beats beyond BURST_LEN in RD_COLLECT SHALL be impossible by construction.
REQ-023 Simultaneous i_req and d_req in IDLE SHALL be resolved by the policy in Configuration; the loser stays pending and is granted at the next IDLE.
REQ-024 beat_cnt SHALL be $clog2(BURST_LEN) bits wide and SHALL clear on entry to RD_ISSUE and WR_BURST.

Reset
REQ-025 Assertion of rst (low) SHALL immediately force IDLE, beat_cnt=0, err=0, all resp/read/write outputs 0, bmem_addr, bmem_wdata and rdata outputs 0, and the round-robin pointer to favor the data cache.
REQ-026 Reset mid-burst SHALL abandon the transaction; beats arriving after deassertion fall under REQ-022.

Configuration
REQ-027 With BMEM_ARB_RR_EN defined, arbitration SHALL be round-robin, and the last-granted requester loses a tie.
REQ-028 Without BMEM_ARB_RR_EN, the data cache SHALL always win a tie.

Structure
REQ-029 State enum arb_state_t, requester enum arb_sel_t and constants BURST_LEN/BEAT_W defaults SHALL live in the shared package bmem_arb_pkg.
REQ-030 The tie-break logic SHALL be a sub-module arb_rr2, holding the priority pointer, with the fixed-priority path selected by the macro.

Verification
REQ-031 i_req, addr 0x1000_0020, memory returns beats A,B,C,D -> one read with bmem_addr=0x1000_0020; i_resp pulses once with i_rdata={D,C,B,A}.
REQ-032 d_req with d_we=1, d_addr=0x2000_0044, bmem_ready toggling 1,0,1,1,0,1 -> bmem_addr=0x2000_0040, 4 beats accepted in order, d_resp on the cycle after the 4th accepted beat.
REQ-033 i_req and d_req asserted in the same cycle, three times back-to-back -> with RR_EN grants are D,I,D,I,...; without RR_EN, D is granted first each time.
REQ-034 bmem_rvalid with raddr=0xDEAD_0000 during a read of 0x1000_0000 -> beat dropped, err=1, response still carries the 4 correct beats.
REQ-035 rst asserted after the 2nd read beat -> outputs 0 asynchronously; remaining beats after release -> no resp, err stays 0.
